fp_decode: RTL and testbench



---
 rtl/fp_decode.sv | 73 +++++++
 tb/tb_fp_decode.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fp_decode.sv
// Compressed float (sign, 3-bit exp, 4-bit significand) to 12-bit linear.
// Magnitude is rebuilt by an iterative one-bit-per-clock shifter.
module fp_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [2:0]  exp,
  input  logic [3:0]  significand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] d_out,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CONV  = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  logic [1:0]  state;
  logic [10:0] mag;
  logic [2:0]  cnt;
  logic        s_q;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mag       <= '0;
      cnt       <= '0;
      s_q       <= 1'b0;
      out_valid <= 1'b0;
      d_out     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag   <= {7'b0, significand};
            cnt   <= exp;
            s_q   <= sign;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != 3'd0) begin
            mag <= mag << 1;
            cnt <= cnt - 3'd1;
          end else begin
            state <= CONV;
          end
        end
        CONV: begin
          // zero magnitude negates to zero, so -0 needs no special case
          d_out     <= s_q ? (~{1'b0, mag} + 12'd1) : {1'b0, mag};
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_decode.sv
// Directed bench for fp_decode: latency, sign, backpressure, reset abort,
// and an encoder-model round trip over every normalized code.
module tb_fp_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [2:0]  exp;
  logic [3:0]  significand;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] d_out;
  logic        busy;

  int errors = 0;
  int checks = 0;

  fp_decode dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sign        (sign),
    .exp         (exp),
    .significand (significand),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .d_out       (d_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // accept one code at a negedge-aligned point and return after the
  // accept edge, at the following negedge
  task automatic accept(input logic s, input logic [2:0] e,
                        input logic [3:0] m);
    sign        = s;
    exp         = e;
    significand = m;
    in_valid    = 1'b1;
    check("in_ready_before_accept", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_code(input string tag, input logic s,
                          input logic [2:0] e, input logic [3:0] m,
                          input logic [11:0] expd);
    int lat;
    accept(s, e, m);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, int'(e) + 2);
    check({tag, "_dout"}, int'(d_out), int'(expd));
    check({tag, "_in_ready_low"}, int'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, int'(out_valid), 0);
    check({tag, "_idle"}, int'(in_ready), 1);
    check({tag, "_dout_kept"}, int'(d_out), int'(expd));
  endtask

  initial begin
    int lat;
    int m;
    int ee;
    int tr;
    logic [11:0] hold;
    rst         = 1'b1;
    in_valid    = 1'b0;
    sign        = 1'b0;
    exp         = 3'd0;
    significand = 4'd0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_dout", int'(d_out), 0);
    check("rst_busy", int'(busy), 0);

    run_code("small_pos", 1'b0, 3'd0, 4'd5, 12'h005);
    run_code("mid_pos", 1'b0, 3'd3, 4'd9, 12'h048);
    run_code("mid_neg", 1'b1, 3'd3, 4'd9, 12'hFB8);

    // reset mid-SHIFT drops the code
    accept(1'b0, 3'd7, 4'd15);
    repeat (2) @(negedge clk);
    check("busy_in_shift", int'(busy), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_dout", int'(d_out), 0);
    check("abort_busy", int'(busy), 0);
    lat = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) lat++;
    end
    check("abort_no_output", lat, 0);

    run_code("max_neg", 1'b1, 3'd7, 4'd15, 12'h880);
    run_code("neg_zero", 1'b1, 3'd0, 4'd0, 12'h000);
    run_code("max_pos", 1'b0, 3'd7, 4'd15, 12'h780);

    // backpressure: result held while inputs wiggle
    accept(1'b0, 3'd3, 4'd9);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, 5);
    hold = 12'h048;
    for (int i = 0; i < 10; i++) begin
      sign        = ~sign;
      exp         = exp + 3'd1;
      significand = significand + 4'd3;
      in_valid    = (i % 2) == 0;
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_dout", int'(d_out), int'(hold));
      check("bp_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release", int'(out_valid), 0);
    check("bp_dout_after", int'(d_out), int'(hold));

    // round trip through an encoder model, random out_ready
    for (int s = 0; s < 2; s++) begin
      for (int e = 0; e < 8; e++) begin
        for (int sg = 0; sg < 16; sg++) begin
          if (e > 0 && sg < 8) continue;
          m = (sg << e) | ((e > 0) ? int'($urandom_range(0, (1 << e) - 1)) : 0);
          ee = 0;
          while ((m >> ee) > 15) ee++;
          tr = m & ~((1 << ee) - 1);
          if (s == 1) tr = -tr;
          accept(s[0], ee[2:0], 4'(m >> ee));
          lat = 0;
          out_ready = 1'($urandom_range(0, 1));
          while (!(out_valid && out_ready) && lat < 40) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            lat++;
          end
          check("rt_handshake", int'(out_valid && out_ready), 1);
          check("rt_dout", int'(d_out), tr & 12'hFFF);
          @(posedge clk);
          @(negedge clk);
          out_ready = 1'b0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
